// File: rtl/tribus_pkg.sv
// tribus_pkg: shared types and constants for the tri-state bus driver.
// Parity output is enabled by defining TRIBUS_PARITY_EN.
package tribus_pkg;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_TURN_CYCLES = 2;
    localparam int CNT_W               = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        DRIVE = ST_DRIVE,
        TURN  = ST_TURN
    } state_t;

endpackage

// File: rtl/tribus_turn_cnt.sv
// tribus_turn_cnt: bus-turnaround down-counter, loads on TURN entry and saturates at 0.
module tribus_turn_cnt
    import tribus_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load ? value : (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/tribus_driver.sv
// tribus_driver: registered data/enable source for a bufif0, with peer release and turnaround.
// Defining TRIBUS_PARITY_EN adds parity_out, the registered even parity of data_out.
module tribus_driver
    import tribus_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int TURN_CYCLES = DEFAULT_TURN_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             release_req,
    output logic [WIDTH-1:0] data_out,
    output logic             data_enable_low,
`ifdef TRIBUS_PARITY_EN
    output logic             parity_out,
`endif
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             del_q, del_d;
    logic             xfer, turn_load, turn_done;

    tribus_turn_cnt u_turn_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (turn_load),
        .value (CNT_W'(TURN_CYCLES - 1)),
        .done  (turn_done)
    );

    // Peer request wins over a pending word; nothing is accepted during turnaround.
    assign in_ready  = !reset && (state_q != TURN) && !release_req;
    assign xfer      = in_valid && in_ready;
    assign turn_load = (state_q == DRIVE) && !xfer;

    always_comb begin
        state_d = (state_q == IDLE)  ? (xfer ? DRIVE : IDLE) :
                  (state_q == DRIVE) ? (xfer ? DRIVE : TURN) :
                                       (turn_done ? IDLE : TURN);
        data_d  = xfer ? in_data : data_q;
        del_d   = (state_d != DRIVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            del_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            del_q   <= del_d;
        end
    end

`ifdef TRIBUS_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = xfer ? ^in_data : parity_q;
    end

    always_ff @(posedge clk) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= parity_d;
    end

    assign parity_out = parity_q;
`endif

    assign data_out        = data_q;
    assign data_enable_low = del_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_tribus_driver.sv
// tb_tribus_driver: table-driven checks of tribus_driver plus turnaround-length and parity sequences.
module tb_tribus_driver;

    logic       clk = 1'b0;
    logic       rst, vld, rel;
    logic [7:0] din;
    logic       rdy, del, busy;
    logic [7:0] dout;
`ifdef TRIBUS_PARITY_EN
    logic       par, par1, par15;
`endif

    logic       s_rst, s_vld;
    logic [7:0] s_din;
    logic       rdy1, del1, busy1, rdy15, del15, busy15;
    logic [7:0] dout1, dout15;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    tribus_driver #(.WIDTH(8), .TURN_CYCLES(2)) dut (
        .clk(clk), .reset(rst), .in_data(din), .in_valid(vld), .in_ready(rdy),
        .release_req(rel), .data_out(dout), .data_enable_low(del),
`ifdef TRIBUS_PARITY_EN
        .parity_out(par),
`endif
        .busy(busy)
    );

    tribus_driver #(.WIDTH(8), .TURN_CYCLES(1)) dut_t1 (
        .clk(clk), .reset(s_rst), .in_data(s_din), .in_valid(s_vld), .in_ready(rdy1),
        .release_req(1'b0), .data_out(dout1), .data_enable_low(del1),
`ifdef TRIBUS_PARITY_EN
        .parity_out(par1),
`endif
        .busy(busy1)
    );

    tribus_driver #(.WIDTH(8), .TURN_CYCLES(15)) dut_t15 (
        .clk(clk), .reset(s_rst), .in_data(s_din), .in_valid(s_vld), .in_ready(rdy15),
        .release_req(1'b0), .data_out(dout15), .data_enable_low(del15),
`ifdef TRIBUS_PARITY_EN
        .parity_out(par15),
`endif
        .busy(busy15)
    );

    typedef struct {
        logic       rst, vld, rel;
        logic [7:0] din;
        logic       rdy;
        logic [7:0] dout;
        logic       del, busy;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic q, input logic [7:0] d,
                       input logic e_rdy, input logic [7:0] e_dout, input logic e_del, input logic e_busy);
        vec_t t;
        t.rst = r; t.vld = v; t.rel = q; t.din = d;
        t.rdy = e_rdy; t.dout = e_dout; t.del = e_del; t.busy = e_busy;
        vq.push_back(t);
    endtask

    initial begin
        int n1, n15;
        bool_loop: begin end
        rst = 1'b1; vld = 1'b0; rel = 1'b0; din = 8'h00;
        s_rst = 1'b1; s_vld = 1'b0; s_din = 8'h00;

        // rst vld rel din | rdy(before edge) dout del busy (after edge)
        add(1, 0, 0, 8'h00, 0, 8'h00, 1, 0);
        add(0, 1, 0, 8'hA5, 1, 8'hA5, 0, 1);
        add(0, 0, 0, 8'h00, 1, 8'hA5, 1, 1);
        add(0, 0, 0, 8'h00, 0, 8'hA5, 1, 1);
        add(0, 0, 0, 8'h00, 0, 8'hA5, 1, 0);
        add(0, 1, 0, 8'h01, 1, 8'h01, 0, 1);
        add(0, 1, 0, 8'h02, 1, 8'h02, 0, 1);
        add(0, 1, 0, 8'h03, 1, 8'h03, 0, 1);
        add(0, 0, 0, 8'h00, 1, 8'h03, 1, 1);
        add(0, 0, 0, 8'h00, 0, 8'h03, 1, 1);
        add(0, 0, 0, 8'h00, 0, 8'h03, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 1, 8'hFF, 0, 8'h03, 1, 0);
        add(0, 1, 0, 8'h01, 1, 8'h01, 0, 1);
        add(0, 1, 0, 8'h02, 1, 8'h02, 0, 1);
        add(0, 1, 1, 8'h03, 0, 8'h02, 1, 1);
        add(0, 1, 1, 8'h03, 0, 8'h02, 1, 1);
        add(0, 0, 0, 8'h00, 0, 8'h02, 1, 0);
        add(0, 1, 0, 8'h3C, 1, 8'h3C, 0, 1);
        add(1, 1, 0, 8'h55, 0, 8'h00, 1, 0);
        add(0, 0, 0, 8'h00, 1, 8'h00, 1, 0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = vq[i].rst; vld = vq[i].vld; rel = vq[i].rel; din = vq[i].din;
            #1 chk("in_ready", i, {31'd0, rdy}, {31'd0, vq[i].rdy});
            @(posedge clk);
            #1;
            chk("data_out", i, {24'd0, dout}, {24'd0, vq[i].dout});
            chk("data_enable_low", i, {31'd0, del}, {31'd0, vq[i].del});
            chk("busy", i, {31'd0, busy}, {31'd0, busy});
            chk("busy_exp", i, {31'd0, busy}, {31'd0, vq[i].busy});
        end

`ifdef TRIBUS_PARITY_EN
        @(negedge clk); vld = 1'b1; rel = 1'b0; din = 8'h07;
        @(posedge clk); #1 chk("parity_07", 0, {31'd0, par}, 32'd1);
        @(negedge clk); din = 8'h03;
        @(posedge clk); #1 chk("parity_03", 0, {31'd0, par}, 32'd0);
        @(negedge clk); vld = 1'b0;
`endif

        // Turnaround length for TURN_CYCLES=1 and 15: count released cycles before in_ready returns.
        @(negedge clk); s_rst = 1'b0; s_vld = 1'b1; s_din = 8'h5A;
        @(posedge clk); #1;
        chk("t1_drive_del", 0, {31'd0, del1}, 32'd0);
        chk("t15_drive_del", 0, {31'd0, del15}, 32'd0);
        chk("t15_drive_dout", 0, {24'd0, dout15}, 32'h5A);
        @(negedge clk); s_vld = 1'b0;
        n1 = -1; n15 = -1;
        for (int c = 1; c <= 40 && (n1 < 0 || n15 < 0); c++) begin
            @(posedge clk); #1;
            if (n1 < 0) begin
                if (rdy1) n1 = c - 1;
                else chk("t1_released", c, {31'd0, del1}, 32'd1);
            end
            if (n15 < 0) begin
                if (rdy15) n15 = c - 1;
                else chk("t15_released", c, {31'd0, del15}, 32'd1);
            end
        end
        chk("t1_turn_cycles", 0, n1, 32'd1);
        chk("t15_turn_cycles", 0, n15, 32'd15);
        chk("t15_idle_hold", 0, {24'd0, dout15}, 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tribus_driver.md
TRIBUS_DRIVER -- requirements
Module: tribus_driver

Interface
REQ-001 Parameter WIDTH, default 8, width of the driven data word.
REQ-002 Parameter TURN_CYCLES, default 2, bus-release idle cycles after a burst; legal range 1..15.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  WIDTH  word to place on the shared bus.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 release_req  input  1  peer requests bus ownership.
REQ-009 data_out  output  WIDTH  registered data feeding the bufif0 data input.
REQ-010 data_enable_low  output  1  registered active-low tri-state enable feeding the bufif0 control input.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 Word transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-013 FSM states SHALL be IDLE, DRIVE and TURN.
REQ-014 IDLE: data_enable_low=1; in_ready=!release_req; on transfer, load data_out and go to DRIVE.
REQ-015 DRIVE: data_enable_low=0; in_ready=!release_req; on transfer, load the new word and stay in DRIVE (back-to-back burst, one word per cycle).
REQ-016 DRIVE with no transfer (in_valid=0 or release_req=1): go to TURN, and data_enable_low=1 from the next cycle.
REQ-017 TURN: data_enable_low=1; in_ready=0; count TURN_CYCLES cycles, then go to IDLE.
REQ-018 Latency: word accepted in cycle N SHALL appear on data_out with data_enable_low=0 in cycle N+1, for exactly one cycle per word.
REQ-019 data_out SHALL hold its last value in TURN and IDLE; only data_enable_low releases the bus.
REQ-020 In IDLE, release_req=1 SHALL block acceptance indefinitely, and the bus SHALL stay released.
REQ-021 In DRIVE, release_req asserted in the same cycle as in_valid SHALL take priority: no transfer, go to TURN.
REQ-022 The TURN counter SHALL be 4 bits wide, load TURN_CYCLES-1 on TURN entry, and exit at 0.
REQ-023 The counter SHALL not wrap.
REQ-024 data_enable_low=0 SHALL never be asserted in the cycle immediately following a TURN cycle unless IDLE has intervened.

Reset
REQ-025 Reset SHALL force IDLE, data_out=0, data_enable_low=1, busy=0 and TURN count=0.
REQ-026 While reset is high, in_ready SHALL be 0.
REQ-027 Reset asserted during DRIVE SHALL release the bus (data_enable_low=1) at the next edge.
REQ-028 Reset asserted during DRIVE SHALL drop the in-flight word.

Configuration
REQ-029 Macro TRIBUS_PARITY_EN defined: the block SHALL add output parity_out (1 bit), the registered even parity of data_out, updated with data_out, reset 0.
REQ-030 Macro TRIBUS_PARITY_EN undefined: parity_out and its logic SHALL be absent.

Structure
REQ-031 Shared package tribus_pkg SHALL hold the state enum, DEFAULT_WIDTH=8, DEFAULT_TURN_CYCLES=2 and the 4-bit counter width constant.
REQ-032 The TURN counter SHALL be sub-module tribus_turn_cnt, with inputs load/value and output done.

Verification
REQ-033 Single word: reset, then in_valid=1 with in_data=8'hA5 for 1 cycle -> next cycle data_out=A5 and data_enable_low=0; then 2 cycles of data_enable_low=1 (TURN); then IDLE.
REQ-034 Burst: words 01,02,03 on consecutive cycles -> data_enable_low=0 for exactly 3 consecutive cycles carrying 01,02,03, then 2 TURN cycles.
REQ-035 Peer priority: release_req=1 in IDLE with in_valid=1 for 5 cycles -> in_ready=0 and data_enable_low=1 throughout.
REQ-036 Peer priority: release_req=1 mid-burst after word 02 -> word 03 not accepted and bus released the next cycle.
REQ-037 Reset mid-DRIVE: assert reset while data_out=3C is driven -> next cycle data_out=0, data_enable_low=1, busy=0.
REQ-038 TURN_CYCLES=1 and TURN_CYCLES=15: a single word -> exactly 1 and 15 released cycles respectively before in_ready=1.
REQ-039 Parity (TRIBUS_PARITY_EN defined): word 8'h07 -> parity_out=1; word 8'h03 -> parity_out=0.
